// File: rtl/bus_arbiter2.sv
// ---------------------------------------------------------------------------
// bus_arbiter2
//
// Two-master round-robin arbiter between two mips cores (dut0, dut1) and the
// shared device bus. Requests and grants are active-low. At most one grant is
// low at any time. The granted core's adr/wdata/we are steered onto the shared
// bus; read data is broadcast outside this block.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, an owner that has held the bus for TMO_CYCLES consecutive
//   cycles is forced to hand over if the other master is requesting. When
//   undefined, a grant is parked for as long as the owner keeps requesting.
//
// Parameters
//   WIDTH       address/data width
//   TMO_CYCLES  maximum tenure length when ARB_TIMEOUT_EN is defined
//
// Ports
//   clk                 system clock, all state on posedge
//   reset               asynchronous active-high reset
//   breq0_, breq1_      bus requests (active-low)
//   bgrt0_, bgrt1_      bus grants (active-low, decoded from state register)
//   adr0/adr1           per-core address
//   wdata0/wdata1       per-core write data
//   we0/we1             per-core write enable
//   bus_adr             shared-bus address
//   bus_wdata           shared-bus write data
//   bus_we              shared-bus write enable
//   bus_owner           0 = dut0, 1 = dut1; meaningful only while a grant is low
// ---------------------------------------------------------------------------
module bus_arbiter2 #(
  parameter int WIDTH      = 32,
  parameter int TMO_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             breq0_,
  input  logic             breq1_,
  output logic             bgrt0_,
  output logic             bgrt1_,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic [WIDTH-1:0] bus_adr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic             bus_we,
  output logic             bus_owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Master that most recently gave up the bus; the other one wins a tie.
  // Resets to 1 so that dut0 wins the first tie.
  logic last_owner_reg;
  logic bus_owner_reg;

  // Request decode (active-high internally for readability)
  logic req0;
  logic req1;
  assign req0 = ~breq0_;
  assign req1 = ~breq1_;

  // Timeout: true when the current owner has used up its tenure budget
  logic tmo_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt_reg;

  assign tmo_hit = (state_reg != IDLE) && (hold_cnt_reg == CNT_MAX);

  // Counts cycles spent in the current grant state. Any state change clears
  // it; once at CNT_MAX it saturates so a parked grant with no competitor
  // simply stays parked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      hold_cnt_reg <= '0;
    end else if ((state_reg != IDLE) && (hold_cnt_reg != CNT_MAX)) begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && !req1) begin
          state_next = GNT0;
        end else if (req1 && !req0) begin
          state_next = GNT1;
        end else if (req0 && req1) begin
          state_next = last_owner_reg ? GNT0 : GNT1;
        end
      end
      GNT0: begin
        // Release goes straight to the other master when it is waiting, so
        // a handover costs no idle cycle.
        if (!req0) begin
          state_next = req1 ? GNT1 : IDLE;
        end else if (tmo_hit && req1) begin
          state_next = GNT1;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_next = req0 ? GNT0 : IDLE;
        end else if (tmo_hit && req0) begin
          state_next = GNT0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Round-robin history and registered owner flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_reg <= 1'b1;
      bus_owner_reg  <= 1'b0;
    end else begin
      if ((state_reg == GNT0) && (state_next != GNT0)) begin
        last_owner_reg <= 1'b0;
      end else if ((state_reg == GNT1) && (state_next != GNT1)) begin
        last_owner_reg <= 1'b1;
      end

      if ((state_next == GNT0) && (state_reg != GNT0)) begin
        bus_owner_reg <= 1'b0;
      end else if ((state_next == GNT1) && (state_reg != GNT1)) begin
        bus_owner_reg <= 1'b1;
      end
    end
  end

  // Grants come straight from the state register, so they are glitch-free,
  // mutually exclusive and drop the moment reset is asserted.
  assign bgrt0_    = (state_reg != GNT0);
  assign bgrt1_    = (state_reg != GNT1);
  assign bus_owner = bus_owner_reg;

  // -------------------------------------------------------------------------
  // Datapath mux: only the granted core's write enable can reach the bus
  // -------------------------------------------------------------------------
  always_comb begin
    bus_adr   = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state_reg)
      GNT0: begin
        bus_adr   = adr0;
        bus_wdata = wdata0;
        bus_we    = we0;
      end
      GNT1: begin
        bus_adr   = adr1;
        bus_wdata = wdata1;
        bus_we    = we1;
      end
      default: begin
        bus_adr   = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter2
//
// Self-checking bench for bus_arbiter2: directed scenarios followed by random
// request traffic compared against a behavioural arbitration model.
// Honours ARB_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bus_arbiter2;

  localparam int WIDTH = 32;
  localparam int TMO   = 16;
  localparam int NONE  = 2;

  logic             clk;
  logic             reset;
  logic             breq0_;
  logic             breq1_;
  logic             bgrt0_;
  logic             bgrt1_;
  logic [WIDTH-1:0] adr0;
  logic [WIDTH-1:0] adr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             we0;
  logic             we1;
  logic [WIDTH-1:0] bus_adr;
  logic [WIDTH-1:0] bus_wdata;
  logic             bus_we;
  logic             bus_owner;

  int n_tests;
  int n_fail;

  // Behavioural model: who owns the bus (0, 1 or NONE), who released last,
  // how many cycles the current owner has held it, and the owner flag.
  int m_owner;
  int m_last;
  int m_hold;
  int m_bus_owner;

  // Starvation bookkeeping: tenures started by the other master while this
  // one has been continuously waiting.
  int wait_tenures [2];

  bus_arbiter2 #(
    .WIDTH      (WIDTH),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .breq0_    (breq0_),
    .breq1_    (breq1_),
    .bgrt0_    (bgrt0_),
    .bgrt1_    (bgrt1_),
    .adr0      (adr0),
    .adr1      (adr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .we0       (we0),
    .we1       (we1),
    .bus_adr   (bus_adr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_owner (bus_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    breq0_ = 1'b1;
    breq1_ = 1'b1;
    adr0   = '0;
    adr1   = '0;
    wdata0 = '0;
    wdata1 = '0;
    we0    = 1'b0;
    we1    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One clock edge of the reference arbitration rules, given the request
  // levels that were present at that edge.
  task automatic model_step(input bit r0, input bit r1);
    int  nxt;
    bit  rx;
    bit  ro;
    nxt = m_owner;
    if (m_owner == NONE) begin
      if (r0 && !r1)      nxt = 0;
      else if (r1 && !r0) nxt = 1;
      else if (r0 && r1)  nxt = 1 - m_last;
    end else begin
      rx = (m_owner == 0) ? r0 : r1;
      ro = (m_owner == 0) ? r1 : r0;
      if (!rx) begin
        nxt = ro ? (1 - m_owner) : NONE;
      end
`ifdef ARB_TIMEOUT_EN
      else if (ro && (m_hold == TMO - 1)) begin
        nxt = 1 - m_owner;
      end
`endif
    end

    if (nxt != m_owner) begin
      if (m_owner != NONE) m_last = m_owner;
      if (nxt != NONE) m_bus_owner = nxt;
      m_hold = 0;
    end else if (m_owner != NONE && m_hold < TMO - 1) begin
      m_hold++;
    end
    m_owner = nxt;
  endtask

  task automatic model_reset();
    m_owner         = NONE;
    m_last          = 1;
    m_hold          = 0;
    m_bus_owner     = 0;
    wait_tenures[0] = 0;
    wait_tenures[1] = 0;
  endtask

  logic prev_g0;
  logic prev_g1;
  int   tenure0;
  int   tenure1;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_inputs();

    // ---- 1: reset holds grants off even with a request pending ----------
    breq0_ = 1'b0;
    tick();
    tick();
    check("t1_rst_bgrt0", {31'd0, bgrt0_}, 32'd1);
    check("t1_rst_bgrt1", {31'd0, bgrt1_}, 32'd1);
    check("t1_rst_we", {31'd0, bus_we}, 32'd0);
    check("t1_rst_owner", {31'd0, bus_owner}, 32'd0);
    check("t1_rst_adr", bus_adr, 32'd0);
    reset = 1'b0;
    tick();
    check("t1_gnt0_after_rst", {31'd0, bgrt0_}, 32'd0);
    check("t1_gnt1_off", {31'd0, bgrt1_}, 32'd1);

    // ---- 2: tie after reset -> dut0, handover with no bubble, RR tie ----
    idle_inputs();
    do_reset();
    breq0_ = 1'b0;
    breq1_ = 1'b0;
    tick();
    check("t2_tie_first_dut0", {31'd0, bgrt0_}, 32'd0);
    check("t2_tie_first_no1", {31'd0, bgrt1_}, 32'd1);
    breq0_ = 1'b1;
    tick();
    check("t2_handover_g1", {31'd0, bgrt1_}, 32'd0);
    check("t2_handover_g0", {31'd0, bgrt0_}, 32'd1);
    check("t2_handover_own", {31'd0, bus_owner}, 32'd1);
    breq1_ = 1'b1;
    tick();
    check("t2_idle_g0", {31'd0, bgrt0_}, 32'd1);
    check("t2_idle_g1", {31'd0, bgrt1_}, 32'd1);
    check("t2_idle_own_hold", {31'd0, bus_owner}, 32'd1);
    breq0_ = 1'b0;
    breq1_ = 1'b0;
    tick();
    check("t2_tie_rr_dut0", {31'd0, bgrt0_}, 32'd0);

    // ---- 3: datapath follows GNT1, dut0 write blocked -------------------
    idle_inputs();
    tick();
    tick();
    breq1_ = 1'b0;
    tick();
    check("t3_gnt1", {31'd0, bgrt1_}, 32'd0);
    breq0_ = 1'b0;
    we1    = 1'b1;
    adr1   = 32'd20;
    wdata1 = 32'd7;
    we0    = 1'b1;
    adr0   = 32'd99;
    wdata0 = 32'd55;
    #1;
    check("t3_bus_we", {31'd0, bus_we}, 32'd1);
    check("t3_bus_adr", bus_adr, 32'd20);
    check("t3_bus_wdata", bus_wdata, 32'd7);
    we1 = 1'b0;
    #1;
    check("t3_we0_blocked", {31'd0, bus_we}, 32'd0);
    check("t3_owner", {31'd0, bus_owner}, 32'd1);

    // ---- 4: async reset mid-grant ---------------------------------------
    idle_inputs();
    tick();
    tick();
    breq0_ = 1'b0;
    tick();
    we0  = 1'b1;
    adr0 = 32'h1234;
    #1;
    check("t4_pre_we", {31'd0, bus_we}, 32'd1);
    check("t4_pre_adr", bus_adr, 32'h1234);
    reset = 1'b1;
    #1;
    check("t4_async_bgrt0", {31'd0, bgrt0_}, 32'd1);
    check("t4_async_we", {31'd0, bus_we}, 32'd0);
    check("t4_async_adr", bus_adr, 32'd0);
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();

    // ---- 5: long hold by dut0 with dut1 waiting -------------------------
    breq0_ = 1'b0;
    tick();
    check("t5_gnt0", {31'd0, bgrt0_}, 32'd0);
    breq1_ = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k < TMO) check($sformatf("t5_hold_k%0d", k), {31'd0, bgrt1_}, 32'd1);
      else         check("t5_timeout_g1", {31'd0, bgrt1_}, 32'd0);
    end
    check("t5_timeout_g0", {31'd0, bgrt0_}, 32'd1);
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (bgrt0_ !== 1'b0 || k == 100)
        check($sformatf("t5_parked_k%0d", k), {31'd0, bgrt0_}, 32'd0);
    end
    check("t5_parked_g1", {31'd0, bgrt1_}, 32'd1);
`endif

    // ---- 6: random traffic against the model ----------------------------
    idle_inputs();
    do_reset();
    model_reset();
    prev_g0 = 1'b1;
    prev_g1 = 1'b1;
    tenure0 = 0;
    tenure1 = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Requests toggle occasionally so tenures last several cycles
      if ($urandom_range(0, 3) == 0) breq0_ = ~breq0_;
      if ($urandom_range(0, 3) == 0) breq1_ = ~breq1_;
      adr0   = $urandom;
      adr1   = $urandom;
      wdata0 = $urandom;
      wdata1 = $urandom;
      we0    = $urandom_range(0, 1);
      we1    = $urandom_range(0, 1);
      @(posedge clk);
      model_step(!breq0_, !breq1_);
      #1;
      begin
        logic [WIDTH-1:0] e_adr;
        logic [WIDTH-1:0] e_wd;
        logic             e_we;
        e_adr = (m_owner == 0) ? adr0 : (m_owner == 1) ? adr1 : '0;
        e_wd  = (m_owner == 0) ? wdata0 : (m_owner == 1) ? wdata1 : '0;
        e_we  = (m_owner == 0) ? we0 : (m_owner == 1) ? we1 : 1'b0;
        check("rnd_bgrt0", {31'd0, bgrt0_}, {31'd0, (m_owner != 0)});
        check("rnd_bgrt1", {31'd0, bgrt1_}, {31'd0, (m_owner != 1)});
        check("rnd_bus_adr", bus_adr, e_adr);
        check("rnd_bus_wdata", bus_wdata, e_wd);
        check("rnd_bus_we", {31'd0, bus_we}, {31'd0, e_we});
        check("rnd_bus_owner", {31'd0, bus_owner}, m_bus_owner[WIDTH-1:0]);
        check("rnd_mutex", {31'd0, (!bgrt0_ && !bgrt1_)}, 32'd0);
      end

      // Starvation: count new tenures of the other master while waiting
      if (prev_g1 && !bgrt1_) tenure1++;
      if (prev_g0 && !bgrt0_) tenure0++;
      if (breq0_ || !bgrt0_) wait_tenures[0] = 0;
      else if (prev_g1 && !bgrt1_) wait_tenures[0]++;
      if (breq1_ || !bgrt1_) wait_tenures[1] = 0;
      else if (prev_g0 && !bgrt0_) wait_tenures[1]++;
      check("rnd_starve0", {31'd0, (wait_tenures[0] > 2)}, 32'd0);
      check("rnd_starve1", {31'd0, (wait_tenures[1] > 2)}, 32'd0);
      prev_g0 = bgrt0_;
      prev_g1 = bgrt1_;
    end
    $display("[TB] random phase: %0d dut0 tenures, %0d dut1 tenures", tenure0, tenure1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
